// File: rtl/rr_arbiter8.sv
// ============================================================================
// rr_arbiter8 : 8-way round-robin arbiter with hold timeout, registered outputs
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int HCNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        req,
  input  logic              release_i,
  output logic              grant_valid,
  output logic [2:0]        grant_code,
  output logic [7:0]        grant,
  output logic              timeout,
  output logic [HCNT_W-1:0] hold_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(MAX_HOLD - 1);
  localparam logic [HCNT_W-1:0] HOLD_MAX  = HCNT_W'(MAX_HOLD);

  state_t              state, state_nxt;
  logic [2:0]          ptr, ptr_nxt;
  logic                grant_valid_nxt;
  logic [2:0]          grant_code_nxt;
  logic [7:0]          grant_nxt;
  logic                timeout_nxt;
  logic [HCNT_W-1:0]   hold_cnt_nxt;

  logic [2:0]          win;
  logic                win_found;
  logic [2:0]          scan_idx;
  logic                rel_a, rel_b, rel_c;

  // Rotating priority scan: first requester at or after ptr wins.
  always_comb begin
    win       = 3'd0;
    win_found = 1'b0;
    scan_idx  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      scan_idx = ptr + 3'(i);
      if (!win_found && req[scan_idx]) begin
        win       = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  assign rel_a = release_i;
  assign rel_b = !req[grant_code];
  assign rel_c = (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    grant_valid_nxt = grant_valid;
    grant_code_nxt  = grant_code;
    grant_nxt       = grant;
    timeout_nxt     = 1'b0;
    hold_cnt_nxt    = hold_cnt;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt       = BUSY;
          grant_valid_nxt = 1'b1;
          grant_code_nxt  = win;
          grant_nxt       = 8'b1 << win;
          hold_cnt_nxt    = '0;
          ptr_nxt         = win + 3'd1;
        end
      end
      BUSY: begin
        if (rel_a || rel_b || rel_c) begin
          // grant_code deliberately keeps the last owner for downstream muxes
          state_nxt       = IDLE;
          grant_valid_nxt = 1'b0;
          grant_nxt       = 8'h00;
          hold_cnt_nxt    = '0;
          timeout_nxt     = rel_c && !rel_a && !rel_b;
        end else if (hold_cnt < HOLD_MAX) begin
          hold_cnt_nxt = hold_cnt + HCNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      grant_valid <= 1'b0;
      grant_code  <= 3'd0;
      grant       <= 8'h00;
      timeout     <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant_valid <= grant_valid_nxt;
      grant_code  <= grant_code_nxt;
      grant       <= grant_nxt;
      timeout     <= timeout_nxt;
      hold_cnt    <= hold_cnt_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
// ============================================================================
// tb_rr_arbiter8 : directed self-checking bench for rr_arbiter8
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       rel = 1'b0;
  logic [7:0] req4 = 8'h00;
  logic       rel4 = 1'b0;

  logic       gv, to, gv4, to4;
  logic [2:0] code, code4;
  logic [7:0] gnt, gnt4;
  logic [7:0] hold;
  logic [2:0] hold4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(16), .HCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .release_i(rel),
    .grant_valid(gv), .grant_code(code), .grant(gnt),
    .timeout(to), .hold_cnt(hold)
  );

  rr_arbiter8 #(.MAX_HOLD(4), .HCNT_W(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .release_i(rel4),
    .grant_valid(gv4), .grant_code(code4), .grant(gnt4),
    .timeout(to4), .hold_cnt(hold4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input logic [2:0] c);
    check({tag, " gv"}, 32'(gv), 32'd1);
    check({tag, " code"}, 32'(code), 32'(c));
    check({tag, " grant"}, 32'(gnt), 32'(8'b1 << c));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 8'h00; rel = 1'b0; req4 = 8'h00; rel4 = 1'b0;
    tick();
    check("rst gv", 32'(gv), 32'd0);
    check("rst code", 32'(code), 32'd0);
    check("rst grant", 32'(gnt), 32'd0);
    check("rst timeout", 32'(to), 32'd0);
    check("rst hold", 32'(hold), 32'd0);
    rst_n = 1'b1;
  endtask

  // Cycle invariants on both instances, sampled away from the active edge.
  always @(negedge clk) begin
    logic [7:0] e, e4;
    e  = gv  ? (8'b1 << code)  : 8'h00;
    e4 = gv4 ? (8'b1 << code4) : 8'h00;
    check("inv grant", 32'(gnt), 32'(e));
    check("inv grant4", 32'(gnt4), 32'(e4));
    check("inv onehot0", 32'($onehot0(gnt)), 32'd1);
    check("inv to_gv", 32'(to && gv), 32'd0);
    check("inv to_gv4", 32'(to4 && gv4), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- 1: single requester, timeout after 16 cycles, re-grant ----
    do_reset();
    req = 8'h04;
    tick();
    expect_grant("t1 first", 3'd2);
    check("t1 hold0", 32'(hold), 32'd0);
    for (int k = 1; k < 16; k++) begin
      tick();
      check("t1 hold", 32'(hold), 32'(k));
      check("t1 no_to", 32'(to), 32'd0);
    end
    tick();
    check("t1 gv_off", 32'(gv), 32'd0);
    check("t1 timeout", 32'(to), 32'd1);
    check("t1 code_kept", 32'(code), 32'd2);
    check("t1 hold_clr", 32'(hold), 32'd0);
    tick();
    expect_grant("t1 regrant", 3'd2);
    check("t1 to_pulse", 32'(to), 32'd0);
    req = 8'h00;
    tick();
    check("t1 withdraw", 32'(gv), 32'd0);

    // ---- 2: all requesting, release on first BUSY cycle ----
    do_reset();
    req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      tick();
      expect_grant("t2 rr", 3'(n % 8));
      check("t2 no_to", 32'(to), 32'd0);
      rel = 1'b1;
      tick();
      check("t2 gap", 32'(gv), 32'd0);
      check("t2 gap_to", 32'(to), 32'd0);
      rel = 1'b0;
    end

    // ---- 3: wrap-around after granting 6 ----
    do_reset();
    req = 8'h40;
    tick();
    expect_grant("t3 g6", 3'd6);
    req = 8'h41; rel = 1'b1;
    tick();
    check("t3 idle", 32'(gv), 32'd0);
    rel = 1'b0;
    tick();
    expect_grant("t3 wrap0", 3'd0);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    tick();
    expect_grant("t3 then6", 3'd6);
    req = 8'h00;
    tick();

    // ---- 4: owner withdrawal at hold_cnt=4 ----
    do_reset();
    req = 8'h08;
    tick();
    expect_grant("t4 g3", 3'd3);
    for (int k = 0; k < 4; k++) tick();
    check("t4 hold4", 32'(hold), 32'd4);
    req = 8'h00;
    tick();
    check("t4 gv", 32'(gv), 32'd0);
    check("t4 to", 32'(to), 32'd0);
    check("t4 grant", 32'(gnt), 32'd0);
    tick();
    check("t4 stay_idle", 32'(gv), 32'd0);

    // ---- 5: MAX_HOLD=4, release together with last hold cycle ----
    do_reset();
    req4 = 8'h01;
    tick();
    check("t5 gv", 32'(gv4), 32'd1);
    check("t5 code", 32'(code4), 32'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("t5 hold", 32'(hold4), 32'(k));
    end
    rel4 = 1'b1;
    tick();
    check("t5 released", 32'(gv4), 32'd0);
    check("t5 no_to", 32'(to4), 32'd0);
    rel4 = 1'b0;
    // pure timeout on the small instance
    tick();
    check("t5 regrant", 32'(gv4), 32'd1);
    for (int k = 0; k < 3; k++) tick();
    check("t5 hold3", 32'(hold4), 32'd3);
    tick();
    check("t5 timeout", 32'(to4), 32'd1);
    check("t5 to_gv", 32'(gv4), 32'd0);
    req4 = 8'h00;
    tick();
    check("t5 to_once", 32'(to4), 32'd0);

    // ---- 6: asynchronous reset mid-grant ----
    do_reset();
    req = 8'h20;
    tick();
    expect_grant("t6 g5", 3'd5);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 async_gv", 32'(gv), 32'd0);
    check("t6 async_grant", 32'(gnt), 32'd0);
    req = 8'hFF;
    tick();
    rst_n = 1'b1;
    tick();
    expect_grant("t6 ptr_reset", 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
